// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
//   arb_state_t : arbiter state (IDLE = arbitrating, LOCK = burst in progress)
//   wrap_inc    : modular increment used to advance the round-robin pointer
package mux_arb_pkg;

    typedef enum logic {IDLE, LOCK} arb_state_t;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotated-priority picker: returns the first asserted request when scanning
// ptr, ptr+1, ..., ptr+N-1 (mod N).
//   req       : per-requester request vector
//   ptr       : index holding highest priority this cycle
//   gnt_valid : at least one request is asserted
//   gnt_idx   : index of the winning request (0 when gnt_valid=0)
module rr_pick #(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Scan from lowest priority to highest so the last hit (the one
        // closest to ptr) overwrites the others.
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Shares one N:1 data mux between N valid/ready requesters and drives a
// single registered output channel. Round-robin arbitration; a granted
// requester keeps the mux until its in_last beat is accepted.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : per-requester valid
//   in_last    : per-requester last-beat-of-burst flag
//   in_data    : flattened data, requester k at [k*W +: W]
//   in_ready   : per-requester ready (combinational, at most one-hot)
//   out_valid  : registered output valid
//   out_last   : registered last flag of the held beat
//   out_data   : registered data
//   out_sel    : index of the requester whose beat is held
//   out_ready  : downstream ready
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [N-1:0]     in_last,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic             out_last,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    input  logic             out_ready
);

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] owner;

    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_idx;

    logic             load_en;
    logic [SEL_W-1:0] sel_idx;
    logic             sel_ok;
    logic             xfer;
    logic [W-1:0]     sel_data;
    logic             sel_last;

    rr_pick #(.N(N)) u_pick (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Single-entry output register: it can take a new beat when empty or
    // when the held beat is leaving this cycle.
    assign load_en = !out_valid || out_ready;

    // In LOCK only the owner is eligible, regardless of other requests.
    assign sel_idx  = (state == LOCK) ? owner : gnt_idx;
    assign sel_ok   = (state == LOCK) ? in_valid[owner] : gnt_valid;
    assign xfer     = rst_n && load_en && sel_ok;
    assign sel_data = in_data[int'(sel_idx)*W +: W];
    assign sel_last = in_last[sel_idx];

    // rst_n gates ready so nothing is offered while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && (state == LOCK || gnt_valid))
            in_ready[sel_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_sel   <= sel_idx;
                if (state == IDLE) begin
                    ptr <= SEL_W'(wrap_inc(int'(sel_idx), N));
                    if (!sel_last) begin
                        owner <= sel_idx;
                        state <= LOCK;
                    end
                end else if (sel_last) begin
                    state <= IDLE;
                end
            end else begin
                // Bubble: nothing loaded, payload registers keep their value.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter (N=4, W=8).
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_last;
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_ready;
    logic         out_valid;
    logic         out_last;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int tests = 0;
    int fails = 0;

    mux_rr_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    task automatic check_out(input string tag, input logic v, input logic l,
                             input logic [W-1:0] d, input logic [1:0] s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".last"},  32'(out_last),  32'(l));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".sel"},   32'(out_sel),   32'(s));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset: nothing offered even with every requester valid.
        #1;
        check("rst.in_ready", 32'(in_ready), 32'h0);
        repeat (3) tick();
        check_out("rst", 1'b0, 1'b0, 8'h00, 2'd0);
        in_valid = 4'b0000;
        rst_n    = 1'b1;
        tick();
        check_out("idle", 1'b0, 1'b0, 8'h00, 2'd0);
        check("idle.in_ready", 32'(in_ready), 32'h0);

        // Fairness: single-beat traffic from everyone, ptr 0 -> 2 after 6 beats.
        for (int k = 0; k < N; k++) set_data(k, 8'h10 + 8'(k));
        in_valid = 4'b1111;
        in_last  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("rr%0d.in_ready", i), 32'(in_ready), 32'(1 << (i % 4)));
            tick();
            check_out($sformatf("rr%0d", i), 1'b1, 1'b1, 8'h10 + 8'(i % 4), 2'(i % 4));
        end

        // Burst lock on requester 2 (ptr=2) while 0 and 1 stay valid.
        in_valid = 4'b0111;
        in_last  = 4'b1011;
        set_data(2, 8'hAA);
        #1;
        check("lock0.in_ready", 32'(in_ready), 32'b0100);
        tick();
        check_out("lock0", 1'b1, 1'b0, 8'hAA, 2'd2);
        set_data(2, 8'hAB);
        #1;
        check("lock1.in_ready", 32'(in_ready), 32'b0100);
        tick();
        check_out("lock1", 1'b1, 1'b0, 8'hAB, 2'd2);
        set_data(2, 8'hAC);
        in_last = 4'b1111;
        tick();
        check_out("lock2", 1'b1, 1'b1, 8'hAC, 2'd2);
        // ptr=3, requester 3 idle -> wraps to 0.
        in_valid = 4'b0011;
        #1;
        check("unlock.in_ready", 32'(in_ready), 32'b0001);
        tick();
        check_out("unlock", 1'b1, 1'b1, 8'h10, 2'd0);

        // Backpressure: held beat stays put, nothing offered.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'h0);
            tick();
            check_out($sformatf("bp%0d", i), 1'b1, 1'b1, 8'h10, 2'd0);
        end
        // Release: held beat leaves and next (ptr=1 -> requester 1) loads same edge.
        out_ready = 1'b1;
        #1;
        check("bprel.in_ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("bprel", 1'b1, 1'b1, 8'h11, 2'd1);

        // Owner bubble: requester 1 locks (ptr=2 scans 2,3,0,1), then goes idle.
        in_valid = 4'b0010;
        in_last  = 4'b1101;
        set_data(1, 8'hB0);
        tick();
        check_out("own0", 1'b1, 1'b0, 8'hB0, 2'd1);
        in_valid = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("bub%0d.in_ready", i), 32'(in_ready), 32'b0010);
            tick();
            check_out($sformatf("bub%0d", i), 1'b0, 1'b0, 8'hB0, 2'd1);
        end
        in_valid = 4'b1010;
        in_last  = 4'b1111;
        set_data(1, 8'hB1);
        tick();
        check_out("own1", 1'b1, 1'b1, 8'hB1, 2'd1);
        // ptr still 2 -> requester 3 wins, ptr wraps to 0.
        in_valid = 4'b1000;
        #1;
        check("wrap.in_ready", 32'(in_ready), 32'b1000);
        tick();
        check_out("wrap", 1'b1, 1'b1, 8'h13, 2'd3);

        // Reset mid-burst: lock on 2 (ptr 0 -> 3), then async reset between edges.
        in_valid = 4'b0100;
        in_last  = 4'b1011;
        set_data(2, 8'hC0);
        tick();
        check_out("mid0", 1'b1, 1'b0, 8'hC0, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("midrst", 1'b0, 1'b0, 8'h00, 2'd0);
        check("midrst.in_ready", 32'(in_ready), 32'h0);
        #1;
        rst_n    = 1'b1;
        in_valid = 4'b1110;
        in_last  = 4'b1111;
        #1;
        // ptr back at 0 and lock gone -> requester 1 wins.
        check("post.in_ready", 32'(in_ready), 32'b0010);
        tick();
        check_out("post", 1'b1, 1'b1, 8'hB1, 2'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
